code_conv_pipe: RTL and testbench
=================================

# code_conv_pipe

Parametrised, pipelined code converter for the datapath conversion stage. It converts a WIDTH-bit word between binary, Gray, BCD and Excess-3, with the conversion mode chosen per transfer. A valid/ready handshake applies on both sides, and invalid BCD or Excess-3 digits are flagged. It replaces ad-hoc combinational 4-bit converters wherever conversions must stream at one word per cycle under backpressure.

## Interface
Parameters:
- WIDTH, 8: data width in bits; must be a multiple of 4 and at least 4.
- CNT_W, 16: width of the error counter; used only with CODE_CONV_ERRCNT_EN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous and active-high.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the input word this cycle.
- in_data  in  WIDTH  word to convert.
- in_mode  in  2  mode: 00 binary→Gray, 01 BCD→XS3, 10 Gray→binary, 11 XS3→BCD.
- out_valid  out  1  result present.
- out_ready  in  1  sink accepts the result.
- out_data  out  WIDTH  converted word.
- out_err  out  1  at least one digit of this result was invalid.
- err_count  out  CNT_W  saturating count of errored results; only with CODE_CONV_ERRCNT_EN.

## Operation
- An input transfer occurs on a clock edge where in_valid && in_ready.
- An output transfer occurs on a clock edge where out_valid && out_ready.
- The pipeline has two stages, S1 and S2, each with one valid bit.
  - S1 registers in_data and in_mode on an input transfer.
  - The conversion logic sits between S1 and S2.
  - S2 registers out_data and out_err.
- Stage load rules:
  - s2_load = !s2_valid || out_ready.
  - s1_load = !s1_valid || s2_load.
  - in_ready = s1_load. This is a combinational path from out_ready; it is intended.
- Valid-bit update:
  - S2 valid becomes S1 valid on s2_load; otherwise it holds.
  - S1 valid becomes the input transfer result on s1_load; otherwise it holds.
- Data in a stage that is not loading holds stable.
- Mode 00, binary→Gray: g[i] = b[i] ^ b[i+1]; g[WIDTH-1] = b[WIDTH-1].
- Mode 10, Gray→binary: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i], prefix XOR from the MSB down.
- Modes 00 and 10 never set out_err.
- Modes 01 and 11 work per 4-bit digit, independently for each of the WIDTH/4 digits.
  - Mode 01, BCD→XS3: a valid digit is 0..9; output = digit + 3.
  - Mode 11, XS3→BCD: a valid digit is 3..12; output = digit − 3.
  - An invalid digit outputs 4'b0000 and sets out_err. Other digits of the same word still convert normally.
  - No carry passes between digits; all arithmetic is modulo 16.

## Timing
- Reset values: S1 and S2 valid = 0, out_valid = 0, out_data = 0, out_err = 0, err_count = 0.
- in_ready is 1 during and after reset because S1 is empty.
- Reset mid-operation discards all words in flight immediately; no output transfer completes for them.
- Latency: a word accepted at edge k is presented at out_valid/out_data after edge k+1.
  - That is one register stage of latency beyond S1 capture.
  - From in_valid to out_valid is 2 edges.
- Throughput: 1 word per cycle while out_ready = 1.
- Backpressure with out_ready = 0:
  - S2 holds.
  - S1 fills on the next input transfer.
  - in_ready then drops combinationally and the block holds 2 words.
- When out_ready rises with both stages full:
  - out_ready, S2 load and S1 load all happen at the same edge.
  - A new input is accepted at that same edge.
- out_data and out_err must not change while out_valid && !out_ready.
- in_mode is sampled with in_data only. Changing the mode between words needs no bubble.

## Configuration
- CODE_CONV_ERRCNT_EN defined:
  - Adds the err_count port and its register.
  - err_count increments by 1 on each output transfer with out_err = 1.
  - It saturates at 2^CNT_W − 1 and clears only on rst.
- CODE_CONV_ERRCNT_EN undefined:
  - No err_count port and no counter logic.
  - All other behaviour is identical.

## Test plan
- Binary→Gray, WIDTH=8, mode 00, in_data 0x5A, out_ready=1 -> 0x77 appears 2 edges later; out_err=0.
- Gray→binary round trip, mode 10, in_data 0x77 -> out_data 0x5A. Sweep all 256 values; Gray→binary(binary→Gray(x)) == x.
- BCD→XS3, mode 01, in_data 0x47 -> 0x7A, out_err=0. Input 0x4B -> 0x70, out_err=1.
- XS3→BCD, mode 11, in_data 0x7A -> 0x47. Input 0x1D (both digits invalid) -> 0x00, out_err=1, and err_count increments once when CODE_CONV_ERRCNT_EN is defined.
- Backpressure: stream 0x00..0x0F, toggle out_ready randomly -> outputs in order with none lost or duplicated; in_ready=0 only when both stages are full; out_data stable while stalled.
- Assert rst with 2 words in flight -> out_valid=0 and in_ready=1 immediately. After release, the next accepted word is the first output.

Source files
------------

// File: rtl/code_conv_pipe_if.sv
// Handshake bundle for code_conv_pipe: input word/mode with valid/ready,
// converted result/error flag with valid/ready.
interface code_conv_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/code_conv_pipe.sv
// Two-stage valid/ready pipelined binary/Gray/BCD/Excess-3 converter.
// Optional saturating error counter enabled by defining CODE_CONV_ERRCNT_EN.
module code_conv_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    code_conv_pipe_if.slave bus
`ifdef CODE_CONV_ERRCNT_EN
    ,
    output logic [CNT_W-1:0] err_count
`endif
);
    localparam int unsigned NDIG = WIDTH / 4;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic [1:0]       r_s1_mode;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_data;
    logic             r_s2_err;

    logic             w_s1_load;
    logic             w_s2_load;
    logic [WIDTH-1:0] w_conv;
    logic             w_err;
    logic             w_acc;
    logic [3:0]       w_dig;

    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
        $error("code_conv_pipe: WIDTH must be a multiple of 4 and at least 4");
    end

    assign w_s2_load    = !r_s2_valid || bus.out_ready;
    assign w_s1_load    = !r_s1_valid || w_s2_load;
    assign bus.in_ready = w_s1_load;

    assign bus.out_valid = r_s2_valid;
    assign bus.out_data  = r_s2_data;
    assign bus.out_err   = r_s2_err;

    always_comb begin
        w_conv = '0;
        w_err  = 1'b0;
        w_acc  = 1'b0;
        w_dig  = '0;
        case (r_s1_mode)
            2'b00: w_conv = r_s1_data ^ (r_s1_data >> 1);
            2'b10: begin
                // Prefix XOR walks from the MSB down
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    w_acc = w_acc ^ r_s1_data[WIDTH-1-i];
                    w_conv[WIDTH-1-i] = w_acc;
                end
            end
            2'b01: begin
                for (int unsigned d = 0; d < NDIG; d++) begin
                    w_dig = r_s1_data[4*d +: 4];
                    if (w_dig <= 4'd9) begin
                        w_conv[4*d +: 4] = w_dig + 4'd3;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            default: begin
                for (int unsigned d = 0; d < NDIG; d++) begin
                    w_dig = r_s1_data[4*d +: 4];
                    if (w_dig >= 4'd3 && w_dig <= 4'd12) begin
                        w_conv[4*d +: 4] = w_dig - 4'd3;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_err   <= 1'b0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_data <= bus.in_data;
                    r_s1_mode <= bus.in_mode;
                end
            end
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= w_conv;
                    r_s2_err  <= w_err;
                end
            end
        end
    end

`ifdef CODE_CONV_ERRCNT_EN
    logic [CNT_W-1:0] r_err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (r_s2_valid && bus.out_ready && r_s2_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign err_count = r_err_count;
`else
    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("code_conv_pipe: CNT_W must be nonzero");
    end
`endif
endmodule

// File: tb/tb_code_conv_pipe.sv
// Self-checking bench for code_conv_pipe: vector table, Gray round trip,
// random backpressure and mid-flight reset.
module tb_code_conv_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   err_exp = 0;

    code_conv_pipe_if #(.WIDTH(8)) bus ();

`ifdef CODE_CONV_ERRCNT_EN
    logic [15:0] err_count;
    code_conv_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .err_count(err_count)
    );
`else
    code_conv_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] din;
        logic [7:0] dout;
        logic       err;
    } vec_t;

    vec_t       tbl[16];
    logic [7:0] src[256];
    logic [1:0] smode[256];
    logic [7:0] expd[256];
    logic       eerr[256];
    logic [7:0] got[256];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Streams n words from src/smode, comparing results in order against expd/eerr
    task automatic run_stream(input int n, input bit rnd);
        int sent = 0;
        int rcvd = 0;
        int inflight = 0;
        int cyc = 0;
        int idx;
        bit held = 1'b0;
        logic [7:0] hd = '0;
        logic he = 1'b0;
        while (rcvd < n && cyc < 4000) begin
            @(negedge clk);
            idx = (sent < n) ? sent : 0;
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_valid  = (sent < n);
            bus.in_data   = src[idx];
            bus.in_mode   = smode[idx];
            #1;
            chk("in_ready", 32'(bus.in_ready), 32'(!(inflight == 2 && !bus.out_ready)));
            if (held) begin
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_data", 32'(bus.out_data), 32'(hd));
                chk("stall_err", 32'(bus.out_err), 32'(he));
                held = 1'b0;
            end
            if (bus.out_valid && !bus.out_ready) begin
                held = 1'b1;
                hd = bus.out_data;
                he = bus.out_err;
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("out_data", 32'(bus.out_data), 32'(expd[rcvd]));
                chk("out_err", 32'(bus.out_err), 32'(eerr[rcvd]));
                got[rcvd] = bus.out_data;
                if (eerr[rcvd]) err_exp++;
                rcvd++;
                inflight--;
            end
            if (bus.in_valid && bus.in_ready) begin
                sent++;
                inflight++;
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        if (rcvd < n) chk("stream_timeout", 32'(rcvd), 32'(n));
        @(posedge clk);
    endtask

    initial begin
        bit found;
        tbl[0]  = '{2'b00, 8'h5A, 8'h77, 1'b0};
        tbl[1]  = '{2'b00, 8'h00, 8'h00, 1'b0};
        tbl[2]  = '{2'b00, 8'hFF, 8'h80, 1'b0};
        tbl[3]  = '{2'b00, 8'h80, 8'hC0, 1'b0};
        tbl[4]  = '{2'b10, 8'h77, 8'h5A, 1'b0};
        tbl[5]  = '{2'b10, 8'h80, 8'hFF, 1'b0};
        tbl[6]  = '{2'b10, 8'hC0, 8'h80, 1'b0};
        tbl[7]  = '{2'b10, 8'hFF, 8'hAA, 1'b0};
        tbl[8]  = '{2'b01, 8'h47, 8'h7A, 1'b0};
        tbl[9]  = '{2'b01, 8'h4B, 8'h70, 1'b1};
        tbl[10] = '{2'b01, 8'h99, 8'hCC, 1'b0};
        tbl[11] = '{2'b01, 8'hA0, 8'h03, 1'b1};
        tbl[12] = '{2'b11, 8'h7A, 8'h47, 1'b0};
        tbl[13] = '{2'b11, 8'h1D, 8'h00, 1'b1};
        tbl[14] = '{2'b11, 8'h33, 8'h00, 1'b0};
        tbl[15] = '{2'b11, 8'hC2, 8'h90, 1'b1};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_err", 32'(bus.out_err), 32'd0);
`ifdef CODE_CONV_ERRCNT_EN
        chk("rst_err_count", 32'(err_count), 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Latency: accepted at edge k, visible after edge k+1
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h5A;
        bus.in_mode   = 2'b00;
        #1;
        chk("lat_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("lat_valid_k", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid_k1", 32'(bus.out_valid), 32'd1);
        chk("lat_data", 32'(bus.out_data), 32'h77);
        chk("lat_err", 32'(bus.out_err), 32'd0);
        @(posedge clk);

        // Vector table, back-to-back with mode changes between words
        for (int i = 0; i < 16; i++) begin
            src[i]   = tbl[i].din;
            smode[i] = tbl[i].mode;
            expd[i]  = tbl[i].dout;
            eerr[i]  = tbl[i].err;
        end
        run_stream(16, 1'b0);

        // Gray round trip over all 256 values
        for (int i = 0; i < 256; i++) begin
            src[i]   = 8'(i);
            smode[i] = 2'b00;
            expd[i]  = 8'(i ^ (i >> 1));
            eerr[i]  = 1'b0;
        end
        run_stream(256, 1'b0);
        for (int i = 0; i < 256; i++) begin
            src[i]   = got[i];
            smode[i] = 2'b10;
            expd[i]  = 8'(i);
        end
        run_stream(256, 1'b0);

        // Random backpressure stream 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            src[i]   = 8'(i);
            smode[i] = 2'b00;
            expd[i]  = 8'(i ^ (i >> 1));
            eerr[i]  = 1'b0;
        end
        run_stream(16, 1'b1);

`ifdef CODE_CONV_ERRCNT_EN
        chk("err_count", 32'(err_count), 32'(err_exp));
`endif

        // Reset with two words in flight
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h11;
        bus.in_mode   = 2'b00;
        @(negedge clk);
        bus.in_data = 8'h22;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_out_data", 32'(bus.out_data), 32'd0);
`ifdef CODE_CONV_ERRCNT_EN
        chk("mid_rst_err_count", 32'(err_count), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h12;
        bus.in_mode   = 2'b01;
        @(negedge clk);
        bus.in_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) found = 1'b1;
        end
        chk("post_rst_seen", 32'(found), 32'd1);
        chk("post_rst_data", 32'(bus.out_data), 32'h45);
        chk("post_rst_err", 32'(bus.out_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
